// File: rtl/tsm_pkg.sv
// Shared encodings and defaults for the tsm_sched traffic scheduler.
package tsm_pkg;
  localparam logic [1:0] IDLE_S = 2'd0;
  localparam logic [1:0] CMD_S  = 2'd1;
  localparam logic [1:0] RUN_S  = 2'd2;
  localparam logic [1:0] HOLD_S = 2'd3;

  localparam int TSM_QUEUE_NUM = 8;
  localparam int TSM_QID_W     = 3;
  localparam int HOLD_CNT_W    = 4;
endpackage

// File: rtl/tsm_rr_arbiter.sv
// Priority search over eligible queues starting at a rotating pointer.
// Latency: combinational. Backpressure: none, pure function of elig/ptr.
// TSM_STRICT_PRIO_EN: ignore ptr, lowest index always wins.
module tsm_rr_arbiter import tsm_pkg::*; #(
  parameter int QUEUE_NUM = TSM_QUEUE_NUM,
  parameter int QID_W     = TSM_QID_W
) (
  input  logic [QUEUE_NUM-1:0] elig,
  input  logic [QID_W-1:0]     ptr,
  output logic [QID_W-1:0]     winner,
  output logic                 found
);

`ifdef TSM_STRICT_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < QUEUE_NUM; i++) begin
      if (!found && elig[i]) begin
        found  = 1'b1;
        winner = QID_W'(i);
      end
    end
  end
`else
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    // Walk ptr, ptr+1, ... with wrap; first hit wins.
    for (int i = 0; i < QUEUE_NUM; i++) begin
      idx = (int'(ptr) + i) % QUEUE_NUM;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = QID_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/tsm_sched.sv
// Picks one eligible queue per frame, pulses its select, hands qid to frame gen.
// Latency: 1 cycle request->select. Backpressure: holds valid/qid until ready.
// TSM_STRICT_PRIO_EN selects fixed priority instead of round-robin.
module tsm_sched import tsm_pkg::*; #(
  parameter int QUEUE_NUM   = TSM_QUEUE_NUM,
  parameter int QID_W       = TSM_QID_W,
  parameter int HOLDOFF_CYC = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 test_stop,
  input  logic [QUEUE_NUM-1:0] in_tsm_queue_en,
  input  logic [QUEUE_NUM-1:0] in_tsm_req,
  output logic [QUEUE_NUM-1:0] out_tsm_selected,
  output logic                 out_tsm_gen_valid,
  output logic [QID_W-1:0]     out_tsm_gen_qid,
  input  logic                 in_tsm_gen_ready,
  input  logic                 in_tsm_gen_done,
  output logic [31:0]          out_tsm_grant_cnt
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLDOFF_CYC - 1);

  logic [1:0]            state_q, state_d;
  logic [QUEUE_NUM-1:0]  sel_q, sel_d;
  logic                  vld_q, vld_d;
  logic [QID_W-1:0]      qid_q, qid_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;

  logic [QUEUE_NUM-1:0]  elig;
  logic [QID_W-1:0]      arb_ptr;
  logic [QID_W-1:0]      winner;
  logic                  found;
  logic                  grant;

  assign elig  = in_tsm_req & in_tsm_queue_en;
  assign grant = (state_q == IDLE_S) && !test_stop && found;

  tsm_rr_arbiter #(
    .QUEUE_NUM (QUEUE_NUM),
    .QID_W     (QID_W)
  ) u_arb (
    .elig   (elig),
    .ptr    (arb_ptr),
    .winner (winner),
    .found  (found)
  );

`ifdef TSM_STRICT_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [QID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (winner == QID_W'(QUEUE_NUM - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = '0;
    vld_d   = vld_q;
    qid_d   = qid_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    // Stop flushes to idle but leaves pointer and grant count intact.
    if (test_stop) begin
      state_d = IDLE_S;
      vld_d   = 1'b0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE_S: begin
          if (grant) begin
            sel_d   = QUEUE_NUM'(1) << winner;
            vld_d   = 1'b1;
            qid_d   = winner;
            cnt_d   = cnt_q + 32'd1;
            state_d = CMD_S;
          end
        end
        CMD_S: begin
          if (in_tsm_gen_ready) begin
            vld_d = 1'b0;
            if (in_tsm_gen_done) begin
              state_d = HOLD_S;
              hold_d  = HOLD_LOAD;
            end else begin
              state_d = RUN_S;
            end
          end
        end
        RUN_S: begin
          if (in_tsm_gen_done) begin
            state_d = HOLD_S;
            hold_d  = HOLD_LOAD;
          end
        end
        HOLD_S: begin
          if (hold_q == '0) state_d = IDLE_S;
          else              hold_d  = hold_q - 1'b1;
        end
        default: state_d = IDLE_S;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_S;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      qid_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      qid_q   <= qid_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign out_tsm_selected  = sel_q;
  assign out_tsm_gen_valid = vld_q;
  assign out_tsm_gen_qid   = qid_q;
  assign out_tsm_grant_cnt = cnt_q;

endmodule
